// File: rtl/div_hd_pkg.sv
// rtl/div_hd_pkg.sv - shared types and defaults for the digit-serial divider sequencer
package div_hd_pkg;
  localparam int DIGIT_W = 2;
  localparam logic [DIGIT_W-1:0] DIGIT_ZERO = 2'b00;
  localparam int N_DIGITS_DEF = 101;
  localparam int CLR_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_CLEAR,
    ST_DONE
  } state_t;
endpackage

// File: rtl/div_hd_seq_if.sv
// rtl/div_hd_seq_if.sv - source, divider and quotient digit streams of the sequencer
interface div_hd_seq_if;
  import div_hd_pkg::*;

  logic [DIGIT_W-1:0] src_x_digit;
  logic               src_x_vld;
  logic               src_x_rdy;
  logic [DIGIT_W-1:0] src_d_digit;
  logic               src_d_vld;
  logic               src_d_rdy;
  logic [DIGIT_W-1:0] div_x_value;
  logic               div_x_vld;
  logic               div_x_rdy;
  logic [DIGIT_W-1:0] div_d_value;
  logic               div_d_vld;
  logic               div_d_rdy;
  logic [DIGIT_W-1:0] div_q_value;
  logic               div_out_vld;
  logic               div_out_rdy;
  logic [DIGIT_W-1:0] q_digit;
  logic               q_vld;
  logic               q_rdy;
  logic               q_last;

  modport slave (
    input  src_x_digit, src_x_vld, src_d_digit, src_d_vld,
    input  div_x_rdy, div_d_rdy, div_q_value, div_out_vld, q_rdy,
    output src_x_rdy, src_d_rdy, div_x_value, div_x_vld, div_d_value, div_d_vld,
    output div_out_rdy, q_digit, q_vld, q_last
  );

  modport master (
    output src_x_digit, src_x_vld, src_d_digit, src_d_vld,
    output div_x_rdy, div_d_rdy, div_q_value, div_out_vld, q_rdy,
    input  src_x_rdy, src_d_rdy, div_x_value, div_x_vld, div_d_value, div_d_vld,
    input  div_out_rdy, q_digit, q_vld, q_last
  );
endinterface

// File: rtl/div_hd_digit_feed.sv
// rtl/div_hd_digit_feed.sv - one operand path: pass N_DIGITS source digits, then flush zeros
module div_hd_digit_feed
  import div_hd_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF
) (
  input  logic               clk,
  input  logic               asyn_reset,
  input  logic               cnt_clr,
  input  logic               active,
  input  logic [DIGIT_W-1:0] src_digit,
  input  logic               src_vld,
  output logic               src_rdy,
  output logic [DIGIT_W-1:0] div_value,
  output logic               div_vld,
  input  logic               div_rdy
);
  localparam int CW = $clog2(N_DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(N_DIGITS);

  logic [CW-1:0] cnt;
  logic          flush;

  assign flush = (cnt == CNT_MAX);

  always_comb begin
    div_value = DIGIT_ZERO;
    div_vld   = 1'b0;
    src_rdy   = 1'b0;
    if (active) begin
      if (flush) begin
        div_vld = 1'b1;
      end else begin
        div_value = src_digit;
        div_vld   = src_vld;
        src_rdy   = div_rdy;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (asyn_reset || cnt_clr) begin
      cnt <= '0;
    end else if (active && !flush && src_vld && div_rdy) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/div_hd_seq.sv
// rtl/div_hd_seq.sv - divider operation sequencer; DIV_HD_SEQ_TIMEOUT_EN adds an output-stall watchdog
module div_hd_seq
  import div_hd_pkg::*;
#(
  parameter int N_DIGITS       = N_DIGITS_DEF,
  parameter int CLR_CYCLES     = CLR_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          asyn_reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          div_clr,
  div_hd_seq_if.slave   bus
);
  localparam int QW = $clog2(N_DIGITS + 1);
  localparam logic [QW-1:0] Q_MAX  = QW'(N_DIGITS);
  localparam logic [QW-1:0] Q_LAST = QW'(N_DIGITS - 1);
  localparam int CCW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CCW-1:0] CLR_END = CCW'(CLR_CYCLES - 1);

  if (N_DIGITS < 1 || CLR_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("div_hd_seq: N_DIGITS, CLR_CYCLES and TIMEOUT_CYCLES must be positive");
  end

  state_t          state, state_nx;
  logic [QW-1:0]   q_cnt;
  logic [CCW-1:0]  clr_cnt;
  logic            run, enter_run, q_xfer, q_final, clr_end, timeout_hit;

  assign run       = (state == ST_RUN);
  assign enter_run = (state == ST_IDLE) && start;
  assign q_xfer    = run && bus.div_out_vld && bus.q_rdy;
  assign q_final   = q_xfer && (q_cnt == Q_LAST);
  assign clr_end   = (clr_cnt == CLR_END);

  div_hd_digit_feed #(.N_DIGITS(N_DIGITS)) u_feed_x (
    .clk(clk), .asyn_reset(asyn_reset), .cnt_clr(enter_run), .active(run),
    .src_digit(bus.src_x_digit), .src_vld(bus.src_x_vld), .src_rdy(bus.src_x_rdy),
    .div_value(bus.div_x_value), .div_vld(bus.div_x_vld), .div_rdy(bus.div_x_rdy)
  );

  div_hd_digit_feed #(.N_DIGITS(N_DIGITS)) u_feed_d (
    .clk(clk), .asyn_reset(asyn_reset), .cnt_clr(enter_run), .active(run),
    .src_digit(bus.src_d_digit), .src_vld(bus.src_d_vld), .src_rdy(bus.src_d_rdy),
    .div_value(bus.div_d_value), .div_vld(bus.div_d_vld), .div_rdy(bus.div_d_rdy)
  );

`ifdef DIV_HD_SEQ_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(TIMEOUT_CYCLES - 1);

  logic [SW-1:0] stall_cnt;
  logic          err_lat;

  // The limit-th consecutive stall cycle is the one that aborts.
  assign timeout_hit = run && !q_xfer && (stall_cnt == STALL_LIM);
  assign err         = (state == ST_DONE) && err_lat;

  always_ff @(posedge clk) begin
    if (asyn_reset || enter_run) begin
      stall_cnt <= '0;
      err_lat   <= 1'b0;
    end else if (run) begin
      if (q_xfer)            stall_cnt <= '0;
      else if (!timeout_hit) stall_cnt <= stall_cnt + 1'b1;
      if (timeout_hit)       err_lat   <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_RUN;
      ST_RUN:   if (q_final || timeout_hit) state_nx = ST_CLEAR;
      ST_CLEAR: if (clr_end) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) state <= ST_IDLE;
    else            state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (asyn_reset || enter_run) begin
      q_cnt <= '0;
    end else if (q_xfer && (q_cnt != Q_MAX)) begin
      q_cnt <= q_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (asyn_reset || (state != ST_CLEAR)) begin
      clr_cnt <= '0;
    end else if (!clr_end) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    bus.q_digit     = DIGIT_ZERO;
    bus.q_vld       = 1'b0;
    bus.div_out_rdy = 1'b0;
    bus.q_last      = 1'b0;
    if (run) begin
      bus.q_digit     = bus.div_q_value;
      bus.q_vld       = bus.div_out_vld;
      bus.div_out_rdy = bus.q_rdy;
      bus.q_last      = bus.div_out_vld && (q_cnt == Q_LAST);
    end
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign div_clr = asyn_reset || (state == ST_CLEAR);
endmodule
